chain_code_decoder: RTL and testbench

CHAIN_CODE_DECODER -- requirements
Module: chain_code_decoder

---
 rtl/chain_pkg.sv | 48 ++++
 rtl/chain_bitmap.sv | 32 +++
 rtl/chain_code_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_chain_code_decoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/chain_pkg.sv
// Shared definitions for the chain-code decoder: FSM state encoding,
// Freeman direction codes and the direction-to-delta lookup.
package chain_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_TRACE  = 3'd2,
      ST_CHECK  = 3'd3,
      ST_RASTER = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   // Freeman directions; row grows downwards, column grows to the right
   localparam logic [2:0] DIR_E  = 3'd0;
   localparam logic [2:0] DIR_NE = 3'd1;
   localparam logic [2:0] DIR_N  = 3'd2;
   localparam logic [2:0] DIR_NW = 3'd3;
   localparam logic [2:0] DIR_W  = 3'd4;
   localparam logic [2:0] DIR_SW = 3'd5;
   localparam logic [2:0] DIR_S  = 3'd6;
   localparam logic [2:0] DIR_SE = 3'd7;

   typedef struct packed {
      logic signed [1:0] drow;
      logic signed [1:0] dcol;
   } delta_t;

   // Row/column step for one chain code
   function automatic delta_t chain_delta(input logic [2:0] dir);
      delta_t d;
      d.drow = 2'sd0;
      d.dcol = 2'sd0;
      case (dir)
         DIR_E:  begin d.drow =  2'sd0; d.dcol =  2'sd1; end
         DIR_NE: begin d.drow = -2'sd1; d.dcol =  2'sd1; end
         DIR_N:  begin d.drow = -2'sd1; d.dcol =  2'sd0; end
         DIR_NW: begin d.drow = -2'sd1; d.dcol = -2'sd1; end
         DIR_W:  begin d.drow =  2'sd0; d.dcol = -2'sd1; end
         DIR_SW: begin d.drow =  2'sd1; d.dcol = -2'sd1; end
         DIR_S:  begin d.drow =  2'sd1; d.dcol =  2'sd0; end
         DIR_SE: begin d.drow =  2'sd1; d.dcol =  2'sd1; end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/chain_bitmap.sv
// Bitmap store: 2**ROW_W words of 2**COL_W bits.
// Ports: i_clr_en/i_clr_row clear a whole row; i_set_en/i_set_row/i_set_col
// set one bit (a set wins over a clear of the same row in the same cycle);
// i_rd_row/i_rd_col select the combinational read bit o_rd_bit_c.
module chain_bitmap #(
   parameter int unsigned ROW_W = 7,
   parameter int unsigned COL_W = 7
) (
   input  logic             clk,
   input  logic             i_clr_en,
   input  logic [ROW_W-1:0] i_clr_row,
   input  logic             i_set_en,
   input  logic [ROW_W-1:0] i_set_row,
   input  logic [COL_W-1:0] i_set_col,
   input  logic [ROW_W-1:0] i_rd_row,
   input  logic [COL_W-1:0] i_rd_col,
   output logic             o_rd_bit_c
);
   localparam int unsigned ROWS = 1 << ROW_W;
   localparam int unsigned COLS = 1 << COL_W;

   logic [COLS-1:0] r_mem [ROWS];

   // Contents are deliberately not reset; a row clear pass precedes every use
   always_ff @(posedge clk) begin
      if (i_clr_en) r_mem[i_clr_row] <= '0;
      if (i_set_en) r_mem[i_set_row][i_set_col] <= 1'b1;
   end

   assign o_rd_bit_c = r_mem[i_rd_row][i_rd_col];

endmodule

// File: rtl/chain_code_decoder.sv
// Freeman chain-code decoder: clears a bitmap, traces a closed contour from
// a start pixel, checks closure (and optionally the enclosed area), then
// rasters the bitmap out row-major.
// Ports: clk, reset (sync, active-high); start + start_row/start_col/
// primeter/area request; code/code_valid/code_ready code stream;
// pixel/pixel_valid/pixel_row/pixel_col raster output; done/error result.
// Optional feature: define CHAIN_AREA_CHECK_EN to add the signed-area check.
module chain_code_decoder
   import chain_pkg::*;
#(
   parameter int unsigned ROW_W  = 7,
   parameter int unsigned COL_W  = 7,
   parameter int unsigned PER_W  = 8,
   parameter int unsigned AREA_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ROW_W-1:0]  start_row,
   input  logic [COL_W-1:0]  start_col,
   input  logic [PER_W-1:0]  primeter,
   input  logic [AREA_W-1:0] area,
   input  logic [2:0]        code,
   input  logic              code_valid,
   output logic              code_ready,
   output logic              pixel,
   output logic              pixel_valid,
   output logic [ROW_W-1:0]  pixel_row,
   output logic [COL_W-1:0]  pixel_col,
   output logic              done,
   output logic              error
);
   localparam int unsigned ADDR_W = ROW_W + COL_W;

   state_t             r_state, w_next;
   logic               w_fail;
   logic [ROW_W-1:0]   r_row, r_srow, r_clr_row;
   logic [COL_W-1:0]   r_col, r_scol;
   logic [PER_W-1:0]   r_per, r_cnt;
   logic               r_code_ready, r_pixel, r_pixel_valid, r_done, r_error;
   logic [ROW_W-1:0]   r_pixel_row;
   logic [COL_W-1:0]   r_pixel_col;

   delta_t             w_delta;
   logic signed [ROW_W:0] w_nrow;
   logic signed [COL_W:0] w_ncol;
   logic               w_xfer, w_oob, w_last, w_chk_err, w_area_ok;
   logic [ADDR_W-1:0]  w_scan_nxt;
   logic [ROW_W-1:0]   w_rd_row;
   logic [COL_W-1:0]   w_rd_col;
   logic               w_rd_bit;
   logic               w_set_en;
   logic [ROW_W-1:0]   w_set_row;
   logic [COL_W-1:0]   w_set_col;

   // Candidate position; one extra bit makes both underflow and overflow show as MSB
   assign w_delta = chain_delta(code);
   assign w_nrow  = $signed({1'b0, r_row}) + $signed({{(ROW_W-1){w_delta.drow[1]}}, w_delta.drow});
   assign w_ncol  = $signed({1'b0, r_col}) + $signed({{(COL_W-1){w_delta.dcol[1]}}, w_delta.dcol});
   assign w_oob   = w_nrow[ROW_W] | w_ncol[COL_W];
   assign w_xfer  = r_code_ready & code_valid;
   assign w_last  = (r_cnt + PER_W'(1)) == r_per;

`ifdef CHAIN_AREA_CHECK_EN
   localparam int unsigned ACC_W = ROW_W + COL_W + PER_W + 2;
   logic signed [ACC_W-1:0] r_acc, w_acc_nxt, w_cterm, w_rterm, w_abs;

   // Shoelace term col*drow - row*dcol with unit deltas reduces to add/negate
   always_comb begin
      w_cterm = '0;
      w_rterm = '0;
      if (w_delta.drow == 2'b01)      w_cterm =  $signed(ACC_W'(r_col));
      else if (w_delta.drow == 2'b11) w_cterm = -$signed(ACC_W'(r_col));
      if (w_delta.dcol == 2'b01)      w_rterm =  $signed(ACC_W'(r_row));
      else if (w_delta.dcol == 2'b11) w_rterm = -$signed(ACC_W'(r_row));
   end
   assign w_acc_nxt = r_acc + w_cterm - w_rterm;
   assign w_abs     = r_acc[ACC_W-1] ? -r_acc : r_acc;
   assign w_area_ok = (w_abs == $signed(ACC_W'({area, 1'b0})));

   always_ff @(posedge clk) begin
      if (r_state == ST_IDLE && start) r_acc <= '0;
      else if (w_xfer && !w_oob)       r_acc <= w_acc_nxt;
   end
`else
   logic w_unused_area;
   assign w_unused_area = ^area;
   assign w_area_ok     = 1'b1;
`endif

   assign w_chk_err = (r_row != r_srow) || (r_col != r_scol) || !w_area_ok;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic; w_fail qualifies the error reported on entry to DONE
   always_comb begin
      w_next = r_state;
      w_fail = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (primeter == '0) begin
                  w_next = ST_DONE;
                  w_fail = 1'b1;
               end else begin
                  w_next = ST_CLEAR;
               end
            end
         end
         ST_CLEAR:  if (&r_clr_row) w_next = ST_TRACE;
         ST_TRACE: begin
            if (w_xfer) begin
               if (w_oob) begin
                  w_next = ST_DONE;
                  w_fail = 1'b1;
               end else if (w_last) begin
                  w_next = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            if (w_chk_err) begin
               w_next = ST_DONE;
               w_fail = 1'b1;
            end else begin
               w_next = ST_RASTER;
            end
         end
         ST_RASTER: if (&{r_pixel_row, r_pixel_col}) w_next = ST_DONE;
         ST_DONE:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Raster read address: (0,0) on entry, otherwise the pixel after the one on the outputs
   assign w_scan_nxt = {r_pixel_row, r_pixel_col} + ADDR_W'(1);
   assign w_rd_row   = (r_state == ST_CHECK) ? '0 : w_scan_nxt[ADDR_W-1:COL_W];
   assign w_rd_col   = (r_state == ST_CHECK) ? '0 : w_scan_nxt[COL_W-1:0];

   // Start pixel is written during the final clear cycle so TRACE starts clean
   assign w_set_en  = ((r_state == ST_CLEAR) && (&r_clr_row)) || (w_xfer && !w_oob);
   assign w_set_row = (r_state == ST_CLEAR) ? r_srow : w_nrow[ROW_W-1:0];
   assign w_set_col = (r_state == ST_CLEAR) ? r_scol : w_ncol[COL_W-1:0];

   chain_bitmap #(.ROW_W(ROW_W), .COL_W(COL_W)) u_bitmap (
      .clk        (clk),
      .i_clr_en   (r_state == ST_CLEAR),
      .i_clr_row  (r_clr_row),
      .i_set_en   (w_set_en),
      .i_set_row  (w_set_row),
      .i_set_col  (w_set_col),
      .i_rd_row   (w_rd_row),
      .i_rd_col   (w_rd_col),
      .o_rd_bit_c (w_rd_bit)
   );

   // Registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_code_ready  <= 1'b0;
         r_pixel_valid <= 1'b0;
         r_pixel       <= 1'b0;
         r_pixel_row   <= '0;
         r_pixel_col   <= '0;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
      end else begin
         r_code_ready  <= (w_next == ST_TRACE);
         r_done        <= (w_next == ST_DONE);
         r_error       <= (w_next == ST_DONE) && w_fail;
         r_pixel_valid <= (w_next == ST_RASTER);
         if (w_next == ST_RASTER) begin
            r_pixel_row <= w_rd_row;
            r_pixel_col <= w_rd_col;
            r_pixel     <= w_rd_bit;
         end else begin
            r_pixel_row <= '0;
            r_pixel_col <= '0;
            r_pixel     <= 1'b0;
         end
      end
   end

   // Request capture, clear sweep and trace position
   always_ff @(posedge clk) begin
      if (r_state == ST_IDLE && start) begin
         r_srow    <= start_row;
         r_scol    <= start_col;
         r_row     <= start_row;
         r_col     <= start_col;
         r_per     <= primeter;
         r_cnt     <= '0;
         r_clr_row <= '0;
      end else begin
         if (r_state == ST_CLEAR) r_clr_row <= r_clr_row + ROW_W'(1);
         if (w_xfer && !w_oob) begin
            r_row <= w_nrow[ROW_W-1:0];
            r_col <= w_ncol[COL_W-1:0];
            r_cnt <= r_cnt + PER_W'(1);
         end
      end
   end

   assign code_ready  = r_code_ready;
   assign pixel       = r_pixel;
   assign pixel_valid = r_pixel_valid;
   assign pixel_row   = r_pixel_row;
   assign pixel_col   = r_pixel_col;
   assign done        = r_done;
   assign error       = r_error;

endmodule

// File: tb/tb_chain_code_decoder.sv
// Directed bench for chain_code_decoder (default 128x128 image).
module tb_chain_code_decoder;
   localparam int NPIX  = 16384;
   localparam int LIMIT = 20000;

   logic        clk = 1'b0;
   logic        reset, start, code_valid;
   logic [6:0]  start_row, start_col;
   logic [7:0]  primeter;
   logic [11:0] area;
   logic [2:0]  code;
   logic        code_ready, pixel, pixel_valid, done, error;
   logic [6:0]  pixel_row, pixel_col;

   chain_code_decoder dut (
      .clk(clk), .reset(reset), .start(start), .start_row(start_row),
      .start_col(start_col), .primeter(primeter), .area(area), .code(code),
      .code_valid(code_valid), .code_ready(code_ready), .pixel(pixel),
      .pixel_valid(pixel_valid), .pixel_row(pixel_row), .pixel_col(pixel_col),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_checks = 0;

   int code_q[$];
   int stall_idx = -1;
   int stall_len = 0;

   logic res_done, res_err, res_ready_at_done, res_done_after;
   int   res_acc, res_valid, res_ones, res_stray, res_order, res_stall_ready, res_cyc;

   function automatic bit is_sq(input logic [6:0] r, input logic [6:0] c);
      return (r == 7'd10 || r == 7'd11) && (c == 7'd10 || c == 7'd11);
   endfunction

   // One complete request: start, feed code_q, collect raster statistics until done
   task automatic run_decode(input logic [6:0] sr, input logic [6:0] sc,
                             input logic [7:0] per, input logic [11:0] ar);
      int idx = 0;
      int cyc = 0;
      int left = stall_len;
      int e = 0;
      res_ones = 0; res_stray = 0; res_order = 0; res_stall_ready = 0;
      @(negedge clk);
      start = 1'b1; start_row = sr; start_col = sc; primeter = per; area = ar;
      @(negedge clk);
      start = 1'b0;
      while (done !== 1'b1 && cyc < LIMIT) begin
         if (pixel_valid === 1'b1) begin
            if ({pixel_row, pixel_col} !== 14'(e)) res_order++;
            if (pixel === 1'b1) begin
               res_ones++;
               if (!is_sq(pixel_row, pixel_col)) res_stray++;
            end
            e++;
         end
         code_valid = 1'b0;
         if (idx < code_q.size()) begin
            if (idx == stall_idx && left > 0) begin
               left--;
               if (code_ready === 1'b1) res_stall_ready++;
            end else begin
               code_valid = 1'b1;
               code = 3'(code_q[idx]);
               if (code_ready === 1'b1) idx++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      code_valid = 1'b0;
      res_done = done; res_err = error; res_ready_at_done = code_ready;
      res_acc = idx; res_valid = e; res_cyc = cyc;
      @(negedge clk);
      res_done_after = done;
   endtask

   // Expectations for a correctly decoded 2x2 square at (10,10)
   task automatic expect_square(input string tag);
      n_checks++; if (res_done !== 1'b1) $display("FAIL %s done: got %b want 1", tag, res_done); else n_pass++;
      n_checks++; if (res_err !== 1'b0) $display("FAIL %s error: got %b want 0", tag, res_err); else n_pass++;
      n_checks++; if (res_acc != 4) $display("FAIL %s codes_taken: got %0d want 4", tag, res_acc); else n_pass++;
      n_checks++; if (res_valid != NPIX) $display("FAIL %s raster_len: got %0d want %0d", tag, res_valid, NPIX); else n_pass++;
      n_checks++; if (res_ones != 4) $display("FAIL %s set_pixels: got %0d want 4", tag, res_ones); else n_pass++;
      n_checks++; if (res_stray != 0) $display("FAIL %s stray_pixels: got %0d want 0", tag, res_stray); else n_pass++;
      n_checks++; if (res_order != 0) $display("FAIL %s raster_order: got %0d bad want 0", tag, res_order); else n_pass++;
      n_checks++; if (res_done_after !== 1'b0) $display("FAIL %s done_pulse: got %b want 0", tag, res_done_after); else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; code_valid = 1'b0; code = 3'd0;
      start_row = '0; start_col = '0; primeter = '0; area = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({code_ready, pixel_valid, pixel, done, error} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000", {code_ready, pixel_valid, pixel, done, error});
      else n_pass++;
      n_checks++;
      if ({pixel_row, pixel_col} !== 14'd0)
         $display("FAIL reset_coords: got %0d want 0", {pixel_row, pixel_col});
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_square();
      code_q = '{0, 6, 4, 2}; stall_idx = -1; stall_len = 0;
      run_decode(7'd10, 7'd10, 8'd4, 12'd1);
      expect_square("square");
   endtask

   task automatic test_open_contour();
      code_q = '{0, 0, 0, 0}; stall_idx = -1; stall_len = 0;
      run_decode(7'd10, 7'd10, 8'd4, 12'd1);
      n_checks++; if (res_done !== 1'b1) $display("FAIL open done: got %b want 1", res_done); else n_pass++;
      n_checks++; if (res_err !== 1'b1) $display("FAIL open error: got %b want 1", res_err); else n_pass++;
      n_checks++; if (res_acc != 4) $display("FAIL open codes_taken: got %0d want 4", res_acc); else n_pass++;
      n_checks++; if (res_valid != 0) $display("FAIL open raster_len: got %0d want 0", res_valid); else n_pass++;
   endtask

   task automatic test_out_of_bounds();
      code_q = '{2, 0, 0, 0}; stall_idx = -1; stall_len = 0;
      run_decode(7'd0, 7'd0, 8'd4, 12'd1);
      n_checks++; if (res_done !== 1'b1) $display("FAIL oob done: got %b want 1", res_done); else n_pass++;
      n_checks++; if (res_err !== 1'b1) $display("FAIL oob error: got %b want 1", res_err); else n_pass++;
      n_checks++; if (res_acc != 1) $display("FAIL oob codes_taken: got %0d want 1", res_acc); else n_pass++;
      n_checks++; if (res_ready_at_done !== 1'b0) $display("FAIL oob ready_after: got %b want 0", res_ready_at_done); else n_pass++;
      n_checks++; if (res_valid != 0) $display("FAIL oob raster_len: got %0d want 0", res_valid); else n_pass++;
   endtask

   task automatic test_stall();
      code_q = '{0, 6, 4, 2}; stall_idx = 2; stall_len = 5;
      run_decode(7'd10, 7'd10, 8'd4, 12'd1);
      expect_square("stall");
      n_checks++;
      if (res_stall_ready != 5) $display("FAIL stall ready_held: got %0d want 5", res_stall_ready);
      else n_pass++;
      stall_idx = -1; stall_len = 0;
   endtask

   task automatic test_area_mismatch();
      logic exp_err;
      int   exp_valid;
`ifdef CHAIN_AREA_CHECK_EN
      exp_err = 1'b1; exp_valid = 0;
`else
      exp_err = 1'b0; exp_valid = NPIX;
`endif
      code_q = '{0, 6, 4, 2};
      run_decode(7'd10, 7'd10, 8'd4, 12'd2);
      n_checks++; if (res_done !== 1'b1) $display("FAIL area2 done: got %b want 1", res_done); else n_pass++;
      n_checks++; if (res_err !== exp_err) $display("FAIL area2 error: got %b want %b", res_err, exp_err); else n_pass++;
      n_checks++; if (res_valid != exp_valid) $display("FAIL area2 raster_len: got %0d want %0d", res_valid, exp_valid); else n_pass++;
   endtask

   task automatic test_reset_mid_trace();
      int wait_cyc = 0;
      @(negedge clk);
      start = 1'b1; start_row = 7'd10; start_col = 7'd10; primeter = 8'd4; area = 12'd1;
      @(negedge clk);
      start = 1'b0;
      while (code_ready !== 1'b1 && wait_cyc < 300) begin
         @(negedge clk);
         wait_cyc++;
      end
      n_checks++;
      if (code_ready !== 1'b1) $display("FAIL midreset trace_entry: got %b want 1", code_ready);
      else n_pass++;
      // Two south moves mark (11,10) and (12,10) before the abort
      code_valid = 1'b1; code = 3'd6;
      repeat (2) @(negedge clk);
      code_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({code_ready, pixel_valid, pixel, done, error} !== 5'b0)
         $display("FAIL midreset flags: got %b want 00000", {code_ready, pixel_valid, pixel, done, error});
      else n_pass++;
      reset = 1'b0;
      code_q = '{0, 6, 4, 2};
      run_decode(7'd10, 7'd10, 8'd4, 12'd1);
      expect_square("after_reset");
      code_q = {};
      run_decode(7'd10, 7'd10, 8'd0, 12'd1);
      n_checks++; if (res_done !== 1'b1) $display("FAIL per0 done: got %b want 1", res_done); else n_pass++;
      n_checks++; if (res_err !== 1'b1) $display("FAIL per0 error: got %b want 1", res_err); else n_pass++;
      n_checks++; if (res_cyc != 0) $display("FAIL per0 latency: got %0d want 0", res_cyc); else n_pass++;
      n_checks++; if (res_valid != 0) $display("FAIL per0 raster_len: got %0d want 0", res_valid); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_square();
      test_open_contour();
      test_out_of_bounds();
      test_stall();
      test_area_mismatch();
      test_reset_mid_trace();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
